// File: rtl/btn_event_pkg.sv
// Shared state encoding and default 50 MHz timing constants for the button gesture controller.
package btn_event_pkg;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StHeld1 = 3'd1,
      StLong  = 3'd2,
      StGap   = 3'd3,
      StHeld2 = 3'd4
   } btn_state_e;

   localparam int unsigned LONG_CYC_DEF   = 50_000_000;
   localparam int unsigned DBL_CYC_DEF    = 15_000_000;
   localparam int unsigned REPEAT_CYC_DEF = 10_000_000;
   localparam int unsigned CNT_W_DEF      = 26;

endpackage

// File: rtl/btn_event_ctrl_if.sv
// Debounced button inputs and gesture event outputs; slave is the controller side.
interface btn_event_ctrl_if;

   logic enable;
   logic db_level;
   logic db_tick;
   logic short_tick;
   logic double_tick;
   logic long_tick;
   logic repeat_tick;
   logic busy;

   modport master (
      output enable, db_level, db_tick,
      input  short_tick, double_tick, long_tick, repeat_tick, busy
   );

   modport slave (
      input  enable, db_level, db_tick,
      output short_tick, double_tick, long_tick, repeat_tick, busy
   );

endinterface

// File: rtl/btn_interval_timer.sv
// Free-running interval counter with synchronous clear; done flags the last cycle of an interval.
module btn_interval_timer #(
   parameter int unsigned CNT_W = 26
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             run,
   input  logic [CNT_W-1:0] limit,
   output logic             done
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (run) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign done = (cnt_q == (limit - CNT_W'(1)));

endmodule

// File: rtl/btn_event_ctrl.sv
// Classifies debounced button activity into short, double, long and auto-repeat event pulses.
module btn_event_ctrl
   import btn_event_pkg::*;
#(
   parameter int unsigned LONG_CYC   = LONG_CYC_DEF,
   parameter int unsigned DBL_CYC    = DBL_CYC_DEF,
   parameter int unsigned REPEAT_CYC = REPEAT_CYC_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF
) (
   input  logic           clk,
   input  logic           reset,
   btn_event_ctrl_if.slave bus
);

   btn_state_e       state_q;
   logic             prev_level_q;
   logic             short_q, double_q, long_q, repeat_q;
   logic             rel;
   logic             clr, run, done;
   logic [CNT_W-1:0] limit;

   assign rel = prev_level_q & ~bus.db_level;

   // Counter restarts on every state change and on each repeat period.
   always_comb begin
      limit = CNT_W'(LONG_CYC);
      clr   = 1'b1;
      run   = 1'b0;
      case (state_q)
         StHeld1: begin
            limit = CNT_W'(LONG_CYC);
            clr   = rel | done;
            run   = 1'b1;
         end
         StLong: begin
            limit = CNT_W'(REPEAT_CYC);
            clr   = rel | done;
            run   = 1'b1;
         end
         StGap: begin
            limit = CNT_W'(DBL_CYC);
            clr   = bus.db_tick | done;
            run   = 1'b1;
         end
         default: begin
            clr = 1'b1;
            run = 1'b0;
         end
      endcase
      if (!bus.enable) begin
         clr = 1'b1;
      end
   end

   btn_interval_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .run   (run),
      .limit (limit),
      .done  (done)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         prev_level_q <= 1'b0;
         short_q      <= 1'b0;
         double_q     <= 1'b0;
         long_q       <= 1'b0;
         repeat_q     <= 1'b0;
      end else begin
         prev_level_q <= bus.db_level;
         short_q      <= 1'b0;
         double_q     <= 1'b0;
         long_q       <= 1'b0;
         repeat_q     <= 1'b0;
         if (!bus.enable) begin
            state_q <= StIdle;
         end else begin
            case (state_q)
               StIdle: begin
                  if (bus.db_tick) state_q <= StHeld1;
               end
               StHeld1: begin
                  if (rel) begin
                     state_q <= StGap;
                  end else if (done) begin
                     state_q <= StLong;
                     long_q  <= 1'b1;
                  end
               end
               StLong: begin
                  if (rel) begin
                     state_q <= StIdle;
                  end else if (done) begin
                     repeat_q <= 1'b1;
                  end
               end
               StGap: begin
                  if (bus.db_tick) begin
                     state_q <= StHeld2;
                  end else if (done) begin
                     state_q <= StIdle;
                     short_q <= 1'b1;
                  end
               end
               StHeld2: begin
                  if (rel) begin
                     state_q  <= StIdle;
                     double_q <= 1'b1;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign bus.short_tick  = short_q;
   assign bus.double_tick = double_q;
   assign bus.long_tick   = long_q;
   assign bus.repeat_tick = repeat_q;
   assign bus.busy        = (state_q != StIdle);

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl with LONG_CYC=20, DBL_CYC=8, REPEAT_CYC=5.
module tb_btn_event_ctrl;

   localparam int unsigned LONG_CYC   = 20;
   localparam int unsigned DBL_CYC    = 8;
   localparam int unsigned REPEAT_CYC = 5;

   // Output vector order: {short, double, long, repeat, busy}
   localparam logic [4:0] N = 5'b00000;
   localparam logic [4:0] B = 5'b00001;
   localparam logic [4:0] S = 5'b10000;
   localparam logic [4:0] D = 5'b01000;
   localparam logic [4:0] L = 5'b00101;
   localparam logic [4:0] R = 5'b00011;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   btn_event_ctrl_if bus ();

   btn_event_ctrl #(
      .LONG_CYC   (LONG_CYC),
      .DBL_CYC    (DBL_CYC),
      .REPEAT_CYC (REPEAT_CYC),
      .CNT_W      (26)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [4:0] obs;
   assign obs = {bus.short_tick, bus.double_tick, bus.long_tick, bus.repeat_tick, bus.busy};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input logic [4:0] exp, input string tag);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drive inputs, take one edge, then check outputs produced by that edge.
   task automatic step(input logic lvl, input logic tk, input logic [4:0] exp, input string tag);
      bus.db_level = lvl;
      bus.db_tick  = tk;
      @(posedge clk);
      #1;
      bus.db_tick = 1'b0;
      check(exp, tag);
   endtask

   task automatic hold(input int n, input logic lvl, input logic [4:0] exp, input string tag);
      for (int i = 0; i < n; i++) step(lvl, 1'b0, exp, tag);
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      reset        = 1'b1;
      bus.enable   = 1'b1;
      bus.db_level = 1'b0;
      bus.db_tick  = 1'b0;
      #1;
      check(N, "reset_async");
      @(posedge clk);
      #1;
      check(N, "reset_held");
      reset = 1'b0;
      hold(2, 1'b0, N, "idle");

      // Short press: hold 5, release, short 8 edges after release.
      step(1'b1, 1'b1, B, "short_press");
      hold(4, 1'b1, B, "short_hold");
      step(1'b0, 1'b0, B, "short_rel");
      hold(DBL_CYC - 1, 1'b0, B, "short_gap");
      step(1'b0, 1'b0, S, "short_tick");
      hold(12, 1'b0, N, "short_after");

      // Long press held 32 clocks: long at +20, repeats at +25, +30.
      step(1'b1, 1'b1, B, "long_press");
      hold(LONG_CYC - 1, 1'b1, B, "long_hold");
      step(1'b1, 1'b0, L, "long_tick");
      hold(REPEAT_CYC - 1, 1'b1, B, "long_rep_wait1");
      step(1'b1, 1'b0, R, "repeat_tick1");
      hold(REPEAT_CYC - 1, 1'b1, B, "long_rep_wait2");
      step(1'b1, 1'b0, R, "repeat_tick2");
      step(1'b1, 1'b0, B, "long_hold_end");
      step(1'b0, 1'b0, N, "long_rel");
      hold(10, 1'b0, N, "long_after");

      // Double click: press 3, gap 4, press 3.
      step(1'b1, 1'b1, B, "dbl_press1");
      hold(2, 1'b1, B, "dbl_hold1");
      step(1'b0, 1'b0, B, "dbl_rel1");
      hold(3, 1'b0, B, "dbl_gap");
      step(1'b1, 1'b1, B, "dbl_press2");
      hold(2, 1'b1, B, "dbl_hold2");
      step(1'b0, 1'b0, D, "double_tick");
      hold(10, 1'b0, N, "dbl_after");

      // Release on the same edge as the long threshold: release wins.
      step(1'b1, 1'b1, B, "tie_press");
      hold(LONG_CYC - 1, 1'b1, B, "tie_hold");
      step(1'b0, 1'b0, B, "tie_rel_no_long");
      hold(DBL_CYC - 1, 1'b0, B, "tie_gap");
      step(1'b0, 1'b0, S, "tie_short_tick");
      hold(3, 1'b0, N, "tie_after");

      // Release one edge after long: long only.
      step(1'b1, 1'b1, B, "l21_press");
      hold(LONG_CYC - 1, 1'b1, B, "l21_hold");
      step(1'b1, 1'b0, L, "l21_long_tick");
      step(1'b0, 1'b0, N, "l21_rel");
      hold(10, 1'b0, N, "l21_after");

      // Async reset while in LONG, while long_tick is still high.
      step(1'b1, 1'b1, B, "rst_press");
      hold(LONG_CYC - 1, 1'b1, B, "rst_hold");
      step(1'b1, 1'b0, L, "rst_long_tick");
      #2;
      reset        = 1'b1;
      bus.db_level = 1'b0;
      #1;
      check(N, "rst_mid_long");
      @(posedge clk);
      #1;
      check(N, "rst_mid_long_held");
      reset = 1'b0;
      hold(8, 1'b0, N, "rst_after");
      step(1'b1, 1'b1, B, "rst_short_press");
      hold(4, 1'b1, B, "rst_short_hold");
      step(1'b0, 1'b0, B, "rst_short_rel");
      hold(DBL_CYC - 1, 1'b0, B, "rst_short_gap");
      step(1'b0, 1'b0, S, "rst_short_tick");
      hold(3, 1'b0, N, "rst_short_after");

      // Enable dropped for one clock during GAP discards the gesture.
      step(1'b1, 1'b1, B, "en_press");
      hold(4, 1'b1, B, "en_hold");
      step(1'b0, 1'b0, B, "en_rel");
      hold(2, 1'b0, B, "en_gap");
      bus.enable = 1'b0;
      step(1'b0, 1'b0, N, "en_low");
      bus.enable = 1'b1;
      hold(12, 1'b0, N, "en_no_short");

      // Second press on the GAP timeout edge: press wins.
      step(1'b1, 1'b1, B, "gt_press1");
      hold(2, 1'b1, B, "gt_hold1");
      step(1'b0, 1'b0, B, "gt_rel1");
      hold(DBL_CYC - 1, 1'b0, B, "gt_gap");
      step(1'b1, 1'b1, B, "gt_press_on_timeout");
      hold(2, 1'b1, B, "gt_hold2");
      step(1'b0, 1'b0, D, "gt_double_tick");
      hold(12, 1'b0, N, "gt_after");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
